// File: rtl/dmem_dump_pkg.sv
// dmem_dump_pkg: FSM state encodings and address stride shared by the BRAM dump reader.
package dmem_dump_pkg;
  typedef enum logic [2:0] {
    DUMP_IDLE = 3'd0,
    DUMP_ADDR = 3'd1,
    DUMP_WAIT = 3'd2,
    DUMP_SEND = 3'd3,
    DUMP_DONE = 3'd4
  } dump_state_e;
  localparam int DUMP_WORD_STRIDE = 4;
endpackage

// File: rtl/dmem_dump_if.sv
// dmem_dump_if: control, BRAM debug port and output stream of the dump reader.
// The checksum member exists only when DMEM_DUMP_CHECKSUM_EN is defined.
interface dmem_dump_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-2:0] word_count;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_last;
`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;
`endif
  modport master (
    output start, abort, start_addr, word_count, dbg_data, out_ready,
    input  busy, done, dbg_addr, out_valid, out_data, out_addr, out_last
`ifdef DMEM_DUMP_CHECKSUM_EN
    , input checksum
`endif
  );
  modport slave (
    input  start, abort, start_addr, word_count, dbg_data, out_ready,
    output busy, done, dbg_addr, out_valid, out_data, out_addr, out_last
`ifdef DMEM_DUMP_CHECKSUM_EN
    , output checksum
`endif
  );
endinterface

// File: rtl/dump_checksum.sv
// dump_checksum: wrapping sum of accepted words with synchronous clear.
module dump_checksum #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sum_o
);
  logic [W-1:0] sum_q, sum_d;
  always_comb sum_d = clr_i ? '0 : en_i ? sum_q + data_i : sum_q;
  always_ff @(posedge clk) sum_q <= rst ? '0 : sum_d;
  assign sum_o = sum_q;
endmodule

// File: rtl/dmem_dump.sv
// dmem_dump: walks a word-aligned BRAM range through the debug port and streams it over valid/ready.
// Define DMEM_DUMP_CHECKSUM_EN to add a running checksum of accepted words.
module dmem_dump
  import dmem_dump_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 0
) (
  input logic        clk,
  input logic        rst,
  dmem_dump_if.slave dump
);
  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, out_addr_q, out_addr_d;
  logic [ADDR_WIDTH-2:0] rem_q, rem_d;
  logic [1:0]            lat_q, lat_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d, hs;
  assign hs = out_valid_q && dump.out_ready && !dump.abort;
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    lat_d       = lat_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    if (dump.abort) begin
      state_d     = DUMP_IDLE;
      addr_d      = '0;
      rem_d       = '0;
      lat_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        DUMP_IDLE: if (dump.start) begin
          state_d = dump.word_count != 0 ? DUMP_ADDR : DUMP_DONE;
          if (dump.word_count != 0) begin
            addr_d = dump.start_addr & ~ADDR_WIDTH'(3);
            rem_d  = dump.word_count;
          end
        end
        DUMP_ADDR: begin
          state_d = DUMP_WAIT;
          lat_d   = 2'(RD_LATENCY);
        end
        // addr_q drives dbg_addr, so it is held until the word is captured
        DUMP_WAIT: if (lat_q == 2'd0) begin
          out_data_d  = dump.dbg_data;
          out_addr_d  = addr_q;
          out_last_d  = rem_q == 1;
          out_valid_d = 1'b1;
          state_d     = DUMP_SEND;
        end else lat_d = lat_q - 2'd1;
        DUMP_SEND: if (hs) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = rem_q == 1 ? DUMP_DONE : DUMP_ADDR;
          rem_d       = rem_q == 1 ? rem_q : rem_q - 1'b1;
          addr_d      = rem_q == 1 ? addr_q : addr_q + ADDR_WIDTH'(DUMP_WORD_STRIDE);
        end
        default: state_d = DUMP_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DUMP_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      lat_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      lat_q       <= lat_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end
  assign dump.busy      = state_q != DUMP_IDLE;
  assign dump.done      = state_q == DUMP_DONE;
  assign dump.dbg_addr  = addr_q;
  assign dump.out_valid = out_valid_q;
  assign dump.out_last  = out_last_q;
  assign dump.out_data  = out_data_q;
  assign dump.out_addr  = out_addr_q;
`ifdef DMEM_DUMP_CHECKSUM_EN
  dump_checksum #(.W(DATA_WIDTH)) u_checksum (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == DUMP_IDLE && dump.start && !dump.abort),
    .en_i  (hs),
    .data_i(out_data_q),
    .sum_o (dump.checksum)
  );
`endif
endmodule

// File: tb/tb_dmem_dump.sv
// tb_dmem_dump: table-driven and randomized checks of dmem_dump against a queue-based model of the dumped range.
module tb_dmem_dump;
  localparam int AW = 10;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_dump_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();
  dmem_dump_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b2 ();
  dmem_dump #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(0)) dut0 (.clk(clk), .rst(rst), .dump(b0));
  dmem_dump #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) dut2 (.clk(clk), .rst(rst), .dump(b2));
  logic [DW-1:0] mem [256];
  logic [DW-1:0] d1, d2;
  assign b0.dbg_data = mem[b0.dbg_addr[AW-1:2]];
  always @(posedge clk) begin
    d1 <= mem[b2.dbg_addr[AW-1:2]];
    d2 <= d1;
  end
  assign b2.dbg_data = d2;
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } word_t;
  typedef struct {
    logic [AW-1:0] sa;
    logic [AW-2:0] wc;
    int            pct;
    logic [AW-1:0] first_a;
    logic [AW-1:0] last_a;
    int            done_cyc;
  } vec_t;
  int vec = 0;
  int errs = 0;
  task automatic chk(input string tag, input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s %s: got %0h, want %0h", tag, nm, act, exp);
    end
  endtask
  task automatic run_dump(input logic [AW-1:0] sa, input logic [AW-2:0] wc, input int pct,
                          input logic [AW-1:0] stall_a, input int stall_n, input int done_cyc,
                          input string tag, output logic [AW-1:0] fa, output logic [AW-1:0] la);
    word_t exp_q[$];
    word_t w;
    logic [AW-1:0] a;
    logic [DW-1:0] sum = '0;
    int got = 0, cyc = 0, last_hs = -10, stalls = 0, rise = -1;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0, fin = 1'b0, stall;
    logic [DW-1:0] pd = '0;
    logic [AW-1:0] pa = '0;
    fa = '0;
    la = '0;
    a = {sa[AW-1:2], 2'b00};
    for (int i = 0; i < int'(wc); i++) begin
      exp_q.push_back('{a: a, d: mem[a[AW-1:2]], l: i == int'(wc) - 1});
      a = a + AW'(4);
    end
    @(negedge clk);
    b0.start_addr = sa;
    b0.word_count = wc;
    b0.start = 1'b1;
    b0.out_ready = 1'b1;
    @(posedge clk);
    #1 b0.start = 1'b0;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      chk(tag, "busy", b0.busy, 1);
      if (pv && !pr) begin
        chk(tag, "hold valid", b0.out_valid, 1);
        chk(tag, "hold data", b0.out_data, pd);
        chk(tag, "hold addr", b0.out_addr, pa);
        chk(tag, "hold last", b0.out_last, pl);
      end
      if (b0.done) begin
        fin = 1'b1;
        chk(tag, "word count", got, wc);
        chk(tag, "valid at done", b0.out_valid, 0);
        if (wc != 0) chk(tag, "done after last hs", cyc - last_hs, 1);
        if (done_cyc >= 0) chk(tag, "done cycle", cyc, done_cyc);
        if (stall_n > 0) chk(tag, "stall cycles", stalls, stall_n);
`ifdef DMEM_DUMP_CHECKSUM_EN
        chk(tag, "checksum", b0.checksum, sum);
`endif
      end
      if (b0.out_valid && !pv) begin
        if (got == 0) chk(tag, "first valid cycle", cyc, 2);
        else if (pct == 100 && stall_n == 0) chk(tag, "word period", cyc - rise, 3);
        rise = cyc;
      end
      stall = stalls < stall_n && b0.out_valid && b0.out_addr == stall_a;
      if (stall) stalls++;
      b0.out_ready = stall ? 1'b0 : (int'($urandom_range(99)) < pct);
      if (b0.out_valid && b0.out_ready) begin
        if (got == 0) fa = b0.out_addr;
        la = b0.out_addr;
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk(tag, "addr", b0.out_addr, w.a);
          chk(tag, "data", b0.out_data, w.d);
          chk(tag, "last", b0.out_last, w.l);
          sum = sum + w.d;
        end
        got++;
        last_hs = cyc;
      end
      pv = b0.out_valid;
      pr = b0.out_ready;
      pd = b0.out_data;
      pa = b0.out_addr;
      pl = b0.out_last;
      cyc++;
    end
    if (!fin) chk(tag, "done timeout", fin, 1);
    @(negedge clk);
    chk(tag, "idle busy", b0.busy, 0);
    chk(tag, "idle done", b0.done, 0);
    chk(tag, "idle valid", b0.out_valid, 0);
  endtask
  task automatic abort_seq(input logic [AW-2:0] wc, input int at_cyc, input logic [DW-1:0] exp_cs, input string tag);
    @(negedge clk);
    b0.start_addr = '0;
    b0.word_count = wc;
    b0.start = 1'b1;
    b0.out_ready = 1'b1;
    @(posedge clk);
    #1 b0.start = 1'b0;
    for (int c = 0; c <= at_cyc; c++) begin
      @(negedge clk);
      if (c == at_cyc) b0.abort = 1'b1;
    end
    @(posedge clk);
    #1 b0.abort = 1'b0;
    @(negedge clk);
    chk(tag, "busy", b0.busy, 0);
    chk(tag, "valid", b0.out_valid, 0);
    chk(tag, "last", b0.out_last, 0);
`ifdef DMEM_DUMP_CHECKSUM_EN
    chk(tag, "checksum kept", b0.checksum, exp_cs);
`else
    if (exp_cs != '0) chk(tag, "done", b0.done, 0);
`endif
    for (int c = 0; c < 4; c++) begin
      chk(tag, "no done", b0.done, 0);
      @(negedge clk);
    end
  endtask
  vec_t tbl[6];
  initial begin
    #500000;
    $display("FAIL watchdog: simulation ran past its time budget");
    $fatal(1);
  end
  initial begin
    logic [AW-1:0] fa, la;
    b0.start = 0; b0.abort = 0; b0.start_addr = '0; b0.word_count = '0; b0.out_ready = 0;
    b2.start = 0; b2.abort = 0; b2.start_addr = '0; b2.word_count = '0; b2.out_ready = 1;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h1; mem[1] = 32'h2; mem[2] = 32'h0; mem[3] = 32'h3;
    tbl[0] = '{sa: 10'h000, wc: 9'd4, pct: 100, first_a: 10'h000, last_a: 10'h00C, done_cyc: 12};
    tbl[1] = '{sa: 10'h3FE, wc: 9'd2, pct: 100, first_a: 10'h3FC, last_a: 10'h000, done_cyc: 6};
    tbl[2] = '{sa: 10'h000, wc: 9'd0, pct: 100, first_a: 10'h000, last_a: 10'h000, done_cyc: 0};
    tbl[3] = '{sa: 10'h013, wc: 9'd1, pct: 100, first_a: 10'h010, last_a: 10'h010, done_cyc: 3};
    tbl[4] = '{sa: 10'h101, wc: 9'd5, pct: 50,  first_a: 10'h100, last_a: 10'h110, done_cyc: -1};
    tbl[5] = '{sa: 10'h3F0, wc: 9'd6, pct: 30,  first_a: 10'h3F0, last_a: 10'h004, done_cyc: -1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", "busy", b0.busy, 0);
    chk("reset", "done", b0.done, 0);
    chk("reset", "valid", b0.out_valid, 0);
    chk("reset", "last", b0.out_last, 0);
    chk("reset", "data", b0.out_data, 0);
    chk("reset", "addr", b0.out_addr, 0);
    chk("reset", "dbg_addr", b0.dbg_addr, 0);
`ifdef DMEM_DUMP_CHECKSUM_EN
    chk("reset", "checksum", b0.checksum, 0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_dump(tbl[i].sa, tbl[i].wc, tbl[i].pct, '0, 0, tbl[i].done_cyc, $sformatf("vec%0d", i), fa, la);
      if (tbl[i].wc != 0) begin
        chk($sformatf("vec%0d", i), "first addr", fa, tbl[i].first_a);
        chk($sformatf("vec%0d", i), "final addr", la, tbl[i].last_a);
      end
    end
    run_dump(10'h000, 9'd4, 100, 10'h004, 5, 17, "backpressure", fa, la);
    abort_seq(9'd4, 4, mem[0], "abort_wait");
    abort_seq(9'd1, 2, '0, "abort_send");
    run_dump(10'h00C, 9'd1, 100, '0, 0, 3, "after_abort", fa, la);
    chk("after_abort", "addr", la, 10'h00C);
    @(negedge clk);
    b0.start_addr = 10'h00C; b0.word_count = 9'd2; b0.start = 1'b1; b0.out_ready = 1'b0;
    @(posedge clk);
    #1 b0.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid", "valid before", b0.out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid", "valid", b0.out_valid, 0);
    chk("rst_mid", "busy", b0.busy, 0);
    chk("rst_mid", "data", b0.out_data, 0);
    chk("rst_mid", "addr", b0.out_addr, 0);
`ifdef DMEM_DUMP_CHECKSUM_EN
    chk("rst_mid", "checksum", b0.checksum, 0);
`endif
    b0.out_ready = 1'b1;
    @(negedge clk);
    b2.start_addr = 10'h00C; b2.word_count = 9'd2; b2.start = 1'b1; b2.out_ready = 1'b1;
    @(posedge clk);
    #1 b2.start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 3) chk("lat2", "early valid", b2.out_valid, 0);
      if (c == 4) begin
        chk("lat2", "valid w0", b2.out_valid, 1);
        chk("lat2", "data w0", b2.out_data, mem[3]);
        chk("lat2", "addr w0", b2.out_addr, 10'h00C);
        chk("lat2", "last w0", b2.out_last, 0);
      end
      if (c == 8) chk("lat2", "gap valid", b2.out_valid, 0);
      if (c == 9) begin
        chk("lat2", "valid w1", b2.out_valid, 1);
        chk("lat2", "data w1", b2.out_data, mem[4]);
        chk("lat2", "addr w1", b2.out_addr, 10'h010);
        chk("lat2", "last w1", b2.out_last, 1);
      end
      if (c == 10) chk("lat2", "done", b2.done, 1);
      if (c == 11) chk("lat2", "busy", b2.busy, 0);
    end
    for (int i = 0; i < 8; i++) begin
      run_dump(AW'($urandom_range(1023)), (AW-1)'($urandom_range(7)), int'($urandom_range(20, 100)),
               '0, 0, -1, $sformatf("rand%0d", i), fa, la);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
